// File: rtl/temp_conditioner.sv
// Conditions the I2C temperature reading: resynchronise, accept stable samples,
// smooth with a moving average, convert to sign-magnitude BCD, flag over-temperature.
module temp_conditioner #(
    parameter int                 CLK_HZ    = 50000000,
    parameter int                 SAMPLE_HZ = 10,
    parameter int                 AVG_LOG2  = 3,
    parameter logic signed [7:0]  ALARM_HI  = 8'sd30,
    parameter logic signed [7:0]  ALARM_LO  = 8'sd28
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic [7:0] temp_raw,
    output logic [7:0] temp_avg,
    output logic       sign,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       disp_valid,
    output logic       over_temp
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int D   = 1 << AVG_LOG2;
    localparam int SW  = 8 + AVG_LOG2;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    logic [7:0]    s_meta, s;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [7:0]    prev;
    logic          prev_valid;
    logic          accept;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            s_meta     <= '0;
            s          <= '0;
            cnt        <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            s_meta <= temp_raw;
            s      <= s_meta;
            cnt    <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                prev       <= s;
                prev_valid <= 1'b1;
            end
        end
    end

    assign tick   = (cnt == CNT_MAX);
    assign accept = tick && prev_valid && (s == prev);

    logic signed [7:0]    avg_buf [D];
    logic [AVG_LOG2-1:0]  wp;
    logic signed [SW-1:0] sum, sum_n, s_ext, old_ext;
    logic signed [7:0]    avg_n;
    logic                 first_flag;
    logic                 avg_upd;

    // The new average is derived from the next sum so temp_avg lands one cycle after the accept.
    always_comb begin
        s_ext   = {{AVG_LOG2{s[7]}}, s};
        old_ext = {{AVG_LOG2{avg_buf[wp][7]}}, avg_buf[wp]};
        sum_n   = first_flag ? (s_ext <<< AVG_LOG2) : (sum - old_ext + s_ext);
        avg_n   = 8'(sum_n >>> AVG_LOG2);
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < D; i++) avg_buf[i] <= '0;
            wp         <= '0;
            sum        <= '0;
            first_flag <= 1'b1;
            temp_avg   <= '0;
            over_temp  <= 1'b0;
            avg_upd    <= 1'b0;
        end else begin
            avg_upd <= accept;
            if (accept) begin
                if (first_flag) begin
                    for (int i = 0; i < D; i++) avg_buf[i] <= s;
                    first_flag <= 1'b0;
                end else begin
                    avg_buf[wp] <= s;
                    wp          <= wp + 1'b1;
                end
                sum      <= sum_n;
                temp_avg <= avg_n;
                if (avg_n >= ALARM_HI)
                    over_temp <= 1'b1;
                else if (avg_n <= ALARM_LO)
                    over_temp <= 1'b0;
            end
        end
    end

    state_t      state, state_n;
    logic [2:0]  iter;
    logic [7:0]  mag;
    logic [3:0]  d_hund, d_tens, d_ones;
    logic        sg;
    logic        pending;
    logic [19:0] dab_vec, dab_shifted;

    function automatic logic [3:0] adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    assign dab_vec     = {adj(d_hund), adj(d_tens), adj(d_ones), mag};
    assign dab_shifted = dab_vec << 1;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // An update arriving outside IDLE is replayed straight from DONE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (avg_upd) state_n = LOAD;
            LOAD:    state_n = SHIFT;
            SHIFT:   if (iter == 3'd7) state_n = DONE;
            DONE:    state_n = (pending || avg_upd) ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            iter       <= '0;
            mag        <= '0;
            d_hund     <= '0;
            d_tens     <= '0;
            d_ones     <= '0;
            sg         <= 1'b0;
            pending    <= 1'b0;
            sign       <= 1'b0;
            bcd_hund   <= '0;
            bcd_tens   <= '0;
            bcd_ones   <= '0;
            disp_valid <= 1'b0;
        end else begin
            disp_valid <= 1'b0;
            if (state == DONE && state_n == LOAD)
                pending <= 1'b0;
            else if (avg_upd && state != IDLE)
                pending <= 1'b1;
            case (state)
                LOAD: begin
                    mag    <= temp_avg[7] ? (~temp_avg + 8'd1) : temp_avg;
                    sg     <= temp_avg[7];
                    d_hund <= '0;
                    d_tens <= '0;
                    d_ones <= '0;
                    iter   <= '0;
                end
                SHIFT: begin
                    {d_hund, d_tens, d_ones, mag} <= dab_shifted;
                    iter <= iter + 1'b1;
                    // Outputs are loaded on entry to DONE so they are valid during the pulse.
                    if (iter == 3'd7) begin
                        sign       <= sg;
                        bcd_hund   <= dab_shifted[19:16];
                        bcd_tens   <= dab_shifted[15:12];
                        bcd_ones   <= dab_shifted[11:8];
                        disp_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_conditioner.sv
// Directed and random bench for temp_conditioner against an arithmetic reference model.
module tb_temp_conditioner;

    logic       clk_50MHz = 1'b0;
    logic       reset;
    logic [7:0] temp_raw;
    logic [7:0] temp_avg;
    logic       sign;
    logic [3:0] bcd_hund, bcd_tens, bcd_ones;
    logic       disp_valid;
    logic       over_temp;

    temp_conditioner #(.CLK_HZ(2000), .SAMPLE_HZ(100)) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .temp_raw  (temp_raw),
        .temp_avg  (temp_avg),
        .sign      (sign),
        .bcd_hund  (bcd_hund),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .disp_valid(disp_valid),
        .over_temp (over_temp)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    int total = 0;
    int bad   = 0;

    // Reference model state: accepted-sample window, alarm, displayed value.
    int m_prev;
    bit m_prev_valid;
    int win[$];
    int m_avg;
    bit m_ot;
    bit m_pend;
    int d_sign, d_h, d_t, d_o;

    function automatic int to_int(input logic [7:0] v);
        return v[7] ? int'(v) - 256 : int'(v);
    endfunction

    function automatic int floor_div8(input int x);
        return (x >= 0) ? x / 8 : -((-x + 7) / 8);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_valid = 1'b0;
        m_prev       = 0;
        win.delete();
        m_avg  = 0;
        m_ot   = 1'b0;
        m_pend = 1'b0;
        d_sign = 0; d_h = 0; d_t = 0; d_o = 0;
    endtask

    task automatic model_tick(input int sv, output bit acc);
        int total_sum;
        acc          = m_prev_valid && (sv == m_prev);
        m_prev       = sv;
        m_prev_valid = 1'b1;
        if (acc) begin
            if (win.size() == 0) begin
                repeat (8) win.push_back(sv);
            end else begin
                void'(win.pop_front());
                win.push_back(sv);
            end
            total_sum = 0;
            foreach (win[j]) total_sum += win[j];
            m_avg = floor_div8(total_sum);
            if (m_avg >= 30)      m_ot = 1'b1;
            else if (m_avg <= 28) m_ot = 1'b0;
        end
    endtask

    task automatic check_display(input string tag);
        check({tag, "_sign"}, 32'(sign), 32'(d_sign));
        check({tag, "_hund"}, 32'(bcd_hund), 32'(d_h));
        check({tag, "_tens"}, 32'(bcd_tens), 32'(d_t));
        check({tag, "_ones"}, 32'(bcd_ones), 32'(d_o));
    endtask

    task automatic do_reset(input logic [7:0] first_v);
        reset = 1'b0;
        #1;
        check("rst_avg", 32'(temp_avg), 32'd0);
        check("rst_ot", 32'(over_temp), 32'd0);
        check("rst_dv", 32'(disp_valid), 32'd0);
        model_reset();
        check_display("rst");
        repeat (3) begin
            @(negedge clk_50MHz);
            check("rst_hold_dv", 32'(disp_valid), 32'd0);
            check("rst_hold_avg", 32'(temp_avg), 32'd0);
        end
        temp_raw = first_v;
        reset    = 1'b1;
    endtask

    // One sample period: 20 clocks, ending just after the tick edge.
    task automatic period(input logic [7:0] v, input int rst_at, input logic [7:0] rst_v);
        bit acc;
        bit exp_dv;
        int mg;
        temp_raw = v;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_50MHz);
            if (i == rst_at) begin
                do_reset(rst_v);
                return;
            end
            exp_dv = (i == 10) && m_pend;
            if (exp_dv) begin
                mg     = (m_avg < 0) ? -m_avg : m_avg;
                d_sign = (m_avg < 0) ? 1 : 0;
                d_h    = mg / 100;
                d_t    = (mg / 10) % 10;
                d_o    = mg % 10;
                m_pend = 1'b0;
                check_display("pulse");
            end
            check("disp_valid", 32'(disp_valid), 32'(exp_dv));
            if (i == 20) begin
                model_tick(to_int(v), acc);
                m_pend = acc;
                check("temp_avg", 32'(temp_avg), 32'(m_avg & 255));
                check("over_temp", 32'(over_temp), 32'(m_ot));
                check_display("hold");
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        reset    = 1'b1;
        temp_raw = 8'd0;
        model_reset();
        @(negedge clk_50MHz);

        // Steady 25, then step up to 33 and back down to 25.
        do_reset(8'd25);
        repeat (3)  period(8'd25, 0, 8'd0);
        repeat (10) period(8'd33, 0, 8'd0);
        repeat (10) period(8'd25, 0, 8'd0);

        // Negative readings, including the most negative value.
        do_reset(8'hF6);
        repeat (3) period(8'hF6, 0, 8'd0);
        do_reset(8'h80);
        repeat (3) period(8'h80, 0, 8'd0);

        // Reading that never settles between ticks.
        for (int k = 0; k < 6; k++) period((k % 2 == 1) ? 8'd21 : 8'd20, 0, 8'd0);

        // Reset in the middle of a conversion.
        do_reset(8'd25);
        repeat (2) period(8'd25, 0, 8'd0);
        period(8'd25, 5, 8'd40);
        repeat (3) period(8'd40, 0, 8'd0);

        // Random readings with random hold lengths.
        v = 8'($urandom_range(0, 255));
        do_reset(v);
        repeat (30) begin
            if ($urandom_range(0, 2) == 0)
                v = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(20, 40));
            period(v, 0, 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
